// File: rtl/tt_issue_dispatch_ctrl.sv
// ============================================================================
// Module   : tt_issue_dispatch_ctrl
// Purpose  : Write/senior/dispatch pointer sequencing for the OVI vector issue
//            FIFO. Optional same-cycle bypass enabled by TT_ISSUE_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tt_issue_dispatch_ctrl #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     issue_valid,
    input  logic                     issue_senior,
    input  logic                     kill,
    input  logic                     vpu_ready,
    output logic                     wr_en,
    output logic [$clog2(DEPTH)-1:0] wr_idx,
    output logic [$clog2(DEPTH)-1:0] rd_idx,
    output logic                     read_valid,
    output logic                     is_empty,
    output logic                     queue_full,
    output logic                     credit_ret,
    output logic                     overflow_err,
    output logic                     senior_err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] C_PTR_ONE = {{AW{1'b0}}, 1'b1};

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0] r_wr;
    logic [AW:0] r_sen;
    logic [AW:0] r_disp;
    logic        r_credit;
    logic        r_overflow;
    logic        r_senior_err;

    logic        w_empty;
    logic        w_full;
    logic        w_push;
    logic        w_senior_ok;
    logic        w_bypass;
    logic        w_read_valid;
    logic        w_fire;
    logic [AW:0] w_sen_next;
    logic [AW:0] w_wr_next;
    logic [AW:0] w_disp_next;

    assign w_empty = (r_wr == r_disp);
    assign w_full  = (r_wr[AW-1:0] == r_disp[AW-1:0]) && (r_wr[AW] != r_disp[AW]);

    // Fullness is judged on registered pointers, so a same-cycle dispatch
    // never makes room for a push.
    assign w_push      = issue_valid && !w_full && !kill;
    assign w_senior_ok = (r_sen != r_wr) || w_push;

`ifdef TT_ISSUE_BYPASS_EN
    assign w_bypass = w_empty && issue_valid && issue_senior && !kill;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_read_valid = (r_disp != r_sen) || w_bypass;
    assign w_fire       = w_read_valid && vpu_ready;

    always_comb begin
        w_sen_next  = r_sen;
        w_wr_next   = r_wr;
        w_disp_next = r_disp;
        if (issue_senior && w_senior_ok) begin
            w_sen_next = r_sen + C_PTR_ONE;
        end
        // Kill rolls the write pointer back onto the (possibly advanced) senior
        // boundary, discarding every speculative entry.
        if (kill) begin
            w_wr_next = w_sen_next;
        end else if (w_push) begin
            w_wr_next = r_wr + C_PTR_ONE;
        end
        if (w_fire) begin
            w_disp_next = r_disp + C_PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr         <= '0;
            r_sen        <= '0;
            r_disp       <= '0;
            r_credit     <= 1'b0;
            r_overflow   <= 1'b0;
            r_senior_err <= 1'b0;
        end else begin
            r_wr     <= w_wr_next;
            r_sen    <= w_sen_next;
            r_disp   <= w_disp_next;
            r_credit <= w_fire;
            if (issue_valid && w_full && !kill) begin
                r_overflow <= 1'b1;
            end
            if (issue_senior && !w_senior_ok) begin
                r_senior_err <= 1'b1;
            end
        end
    end

    assign wr_en        = w_push;
    assign wr_idx       = r_wr[AW-1:0];
    // In bypass the queue is empty, so disp and wr index the same slot.
    assign rd_idx       = w_bypass ? r_wr[AW-1:0] : r_disp[AW-1:0];
    assign read_valid   = w_read_valid;
    assign is_empty     = w_empty;
    assign queue_full   = w_full;
    assign credit_ret   = r_credit;
    assign overflow_err = r_overflow;
    assign senior_err   = r_senior_err;

endmodule

`default_nettype wire

// File: tb/tb_tt_issue_dispatch_ctrl.sv
// ============================================================================
// Module   : tb_tt_issue_dispatch_ctrl
// Purpose  : Directed self-checking bench for tt_issue_dispatch_ctrl (DEPTH=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tt_issue_dispatch_ctrl;

    localparam int DEPTH = 4;
    localparam int AW    = 2;
`ifdef TT_ISSUE_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          issue_valid;
    logic          issue_senior;
    logic          kill;
    logic          vpu_ready;
    logic          wr_en;
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_idx;
    logic          read_valid;
    logic          is_empty;
    logic          queue_full;
    logic          credit_ret;
    logic          overflow_err;
    logic          senior_err;

    int n_cmp  = 0;
    int n_fail = 0;

    tt_issue_dispatch_ctrl #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .issue_valid  (issue_valid),
        .issue_senior (issue_senior),
        .kill         (kill),
        .vpu_ready    (vpu_ready),
        .wr_en        (wr_en),
        .wr_idx       (wr_idx),
        .rd_idx       (rd_idx),
        .read_valid   (read_valid),
        .is_empty     (is_empty),
        .queue_full   (queue_full),
        .credit_ret   (credit_ret),
        .overflow_err (overflow_err),
        .senior_err   (senior_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        issue_valid  = 1'b0;
        issue_senior = 1'b0;
        kill         = 1'b0;
        vpu_ready    = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int fires;
        int credits;

        // Reset and idle
        do_reset();
        chk("rst_empty", is_empty, 1);
        chk("rst_rvalid", read_valid, 0);
        chk("rst_full", queue_full, 0);
        chk("rst_credit", credit_ret, 0);
        chk("rst_ovf", overflow_err, 0);
        chk("rst_serr", senior_err, 0);
        chk("rst_wr_en", wr_en, 0);

        // Fill four speculative entries, then attempt a fifth
        issue_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("fill_wr_en", wr_en, 1);
            chk("fill_wr_idx", wr_idx, i[7:0]);
            chk("fill_full", queue_full, 0);
            tick();
        end
        chk("full_after4", queue_full, 1);
        chk("full_rvalid", read_valid, 0);
        chk("push5_wr_en", wr_en, 0);
        tick();
        issue_valid = 1'b0;
        chk("push5_ovf", overflow_err, 1);
        chk("push5_still_full", queue_full, 1);

        // Push 3, senior one, kill: only slot 0 survives
        do_reset();
        chk("rst2_ovf", overflow_err, 0);
        issue_valid = 1'b1;
        tick(); tick(); tick();
        issue_valid  = 1'b0;
        issue_senior = 1'b1;
        tick();
        issue_senior = 1'b0;
        kill         = 1'b1;
        tick();
        kill = 1'b0;
        #1;
        chk("kill_wr_idx", wr_idx, 1);
        chk("kill_rvalid", read_valid, 1);
        chk("kill_rd_idx", rd_idx, 0);
        chk("kill_serr", senior_err, 0);
        vpu_ready = 1'b1;
        tick();
        vpu_ready = 1'b0;
        #1;
        chk("kill_credit", credit_ret, 1);
        chk("kill_rvalid_after", read_valid, 0);
        chk("kill_empty_after", is_empty, 1);

        // Senior pulse with nothing speculative
        issue_senior = 1'b1;
        tick();
        issue_senior = 1'b0;
        #1;
        chk("serr_flag", senior_err, 1);
        chk("serr_wr_idx", wr_idx, 1);
        chk("serr_rvalid", read_valid, 0);
        chk("serr_empty", is_empty, 1);

        // Stream 10 entries through with wrap-around
        do_reset();
        fires   = 0;
        credits = 0;
        for (int cyc = 0; cyc < 14; cyc++) begin
            if (credit_ret) credits++;
            issue_valid  = (cyc < 10);
            issue_senior = (cyc < 10);
            vpu_ready    = 1'b1;
            #1;
            if (read_valid && vpu_ready) begin
                chk("wrap_rd_idx", rd_idx, 8'(fires % DEPTH));
                fires++;
            end
            tick();
        end
        if (credit_ret) credits++;
        issue_valid  = 1'b0;
        issue_senior = 1'b0;
        vpu_ready    = 1'b0;
        chk("wrap_fires", 8'(fires), 10);
        chk("wrap_credits", 8'(credits), 10);
        chk("wrap_empty", is_empty, 1);

        // Issue-to-dispatch latency from an empty queue
        do_reset();
        issue_valid  = 1'b1;
        issue_senior = 1'b1;
        vpu_ready    = 1'b1;
        #1;
        chk("lat_N_rvalid", read_valid, BYP);
        tick();
        issue_valid  = 1'b0;
        issue_senior = 1'b0;
        #1;
        chk("lat_N1_credit", credit_ret, BYP);
        chk("lat_N1_rvalid", read_valid, !BYP);
        tick();
        vpu_ready = 1'b0;
        chk("lat_N2_credit", credit_ret, !BYP);
        chk("lat_N2_empty", is_empty, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
